// File: rtl/fir_stream_driver_if.sv
// Valid/ready sample stream used on both the upstream (slave) and downstream
// (master) sides of fir_stream_driver.
interface fir_stream_driver_if #(
  parameter int DW = 18
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_stream_driver.sv
// Lossless valid/ready wrapper around the free-running fir core: throttles the core with
// clk_ena and buffers its results. Define FIR_DRV_STALL_CNT_EN to add the stall_cnt port.
module fir_stream_driver #(
  parameter int DW        = 18,
  parameter int OUT_DEPTH = 4,
  parameter int LATENCY   = 18
) (
  input  logic                clk,
  input  logic                reset,
  fir_stream_driver_if.slave  s,
  fir_stream_driver_if.master m,
  output logic                f_clk_ena,
  output logic                f_i_valid,
  output logic [DW-1:0]       f_i_in,
  input  logic                f_o_valid,
  input  logic [DW-1:0]       f_o_out,
  output logic                idle
`ifdef FIR_DRV_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 2);

  logic [DW-1:0] fifo_mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [IW-1:0] in_flight;

  logic fifo_has_room;
  logic push;
  logic pop;
  logic accept;

  // The core may only advance if the result it might retire has somewhere to go.
  assign fifo_has_room = (fifo_count < CW'(OUT_DEPTH));
  assign m.valid       = (fifo_count != '0);
  assign pop           = m.valid && m.ready;
  assign f_clk_ena     = fifo_has_room || pop;

  assign s.ready   = f_clk_ena;
  assign f_i_valid = s.valid;
  assign f_i_in    = s.valid ? s.data : '0;
  assign accept    = s.valid && f_clk_ena;
  assign push      = f_clk_ena && f_o_valid;

  assign m.data = fifo_mem[rd_ptr];
  assign idle   = (in_flight == '0) && (fifo_count == '0);

  // Output FIFO: power-of-two depth, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= f_o_out;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else if (accept && !push) begin
      in_flight <= in_flight + 1'b1;
    end else if (!accept && push) begin
      in_flight <= in_flight - 1'b1;
    end
  end

`ifdef FIR_DRV_STALL_CNT_EN
  // Counts cycles where upstream offered a sample but was held off; saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (s.valid && !f_clk_ena && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_stream_driver.sv
// Self-checking bench for fir_stream_driver with a behavioural 17-tap stand-in for the fir core
// and a queue-based reference model. Define FIR_DRV_STALL_CNT_EN to also test stall_cnt.
module tb_fir_stream_driver;

  localparam int DW        = 18;
  localparam int OUT_DEPTH = 4;
  localparam int LATENCY   = 18;
  localparam int NTAPS     = 17;

  int h [NTAPS] = '{88, 0, -97, -197, -294, -380, -447, -490, -504,
                    -490, -447, -380, -294, -197, -97, 0, 88};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total_checks = 0;
  int   bad_checks   = 0;

  fir_stream_driver_if #(.DW(DW)) s_bus ();
  fir_stream_driver_if #(.DW(DW)) m_bus ();

  logic          f_clk_ena;
  logic          f_i_valid;
  logic [DW-1:0] f_i_in;
  logic          f_o_valid;
  logic [DW-1:0] f_o_out;
  logic          idle;
`ifdef FIR_DRV_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  fir_stream_driver #(.DW(DW), .OUT_DEPTH(OUT_DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s_bus),
    .m         (m_bus),
    .f_clk_ena (f_clk_ena),
    .f_i_valid (f_i_valid),
    .f_i_in    (f_i_in),
    .f_o_valid (f_o_valid),
    .f_o_out   (f_o_out),
    .idle      (idle)
`ifdef FIR_DRV_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in fir core: shifts on every enabled edge, result valid LATENCY enabled edges later.
  logic [DW-1:0] taps  [NTAPS-1];
  logic          vpipe [LATENCY];
  logic [DW-1:0] dpipe [LATENCY];

  function automatic logic [DW-1:0] standInSum();
    longint acc;
    acc = longint'(h[0]) * longint'($signed(f_i_in));
    for (int k = 1; k < NTAPS; k++) begin
      acc += longint'(h[k]) * longint'($signed(taps[k-1]));
    end
    return acc[DW-1:0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS - 1; i++) taps[i] <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vpipe[i] <= 1'b0;
        dpipe[i] <= '0;
      end
    end else if (f_clk_ena) begin
      taps[0]  <= f_i_in;
      for (int i = 1; i < NTAPS - 1; i++) taps[i] <= taps[i-1];
      vpipe[0] <= f_i_valid;
      dpipe[0] <= standInSum();
      for (int i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign f_o_valid = vpipe[LATENCY-1];
  assign f_o_out   = dpipe[LATENCY-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    total_checks++;
    bad_checks++;
    $display("[TB] FAIL %s: bound expired, got timeout, want completion (cycle %0d)", name, cyc);
  endtask

  // Reference model: history of values the core consumed, expected results in stream order.
  logic [DW-1:0] hist  [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            inflight_m = 0;
  int            fifo_m     = 0;
  int            acc_total  = 0;
  int            pop_total  = 0;
  int            first_pop_cyc = -1;
  logic [15:0]   stall_m = '0;
  logic          m_ena, pop_m, acc_m, cap_m;

  function automatic logic [DW-1:0] refFilter();
    longint acc = 0;
    int     n   = hist.size();
    for (int k = 0; k < NTAPS; k++) begin
      if (n - 1 - k >= 0) acc += longint'(h[k]) * longint'($signed(hist[n-1-k]));
    end
    return acc[DW-1:0];
  endfunction

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      hist.delete();
      exp_q.delete();
      inflight_m = 0;
      fifo_m     = 0;
      stall_m    = '0;
    end else begin
      m_ena = (fifo_m < OUT_DEPTH) || ((fifo_m != 0) && m_bus.ready);
      pop_m = (fifo_m != 0) && m_bus.ready;
      acc_m = s_bus.valid && m_ena;
      cap_m = m_ena && f_o_valid;
      checkOutput("f_clk_ena", 32'(f_clk_ena), 32'(m_ena));
      checkOutput("s_ready", 32'(s_bus.ready), 32'(m_ena));
      checkOutput("f_i_valid", 32'(f_i_valid), 32'(s_bus.valid));
      checkOutput("f_i_in", 32'(f_i_in), s_bus.valid ? 32'(s_bus.data) : 32'd0);
      checkOutput("m_valid", 32'(m_bus.valid), 32'(fifo_m != 0));
      checkOutput("idle", 32'(idle), 32'((inflight_m == 0) && (fifo_m == 0)));
      checkOutput("in_flight", 32'(dut.in_flight), 32'(inflight_m));
      checkOutput("in_flight_bound", 32'(dut.in_flight <= LATENCY + 1), 32'd1);
`ifdef FIR_DRV_STALL_CNT_EN
      checkOutput("stall_cnt_track", 32'(stall_cnt), 32'(stall_m));
`endif
      if (pop_m) begin
        if (got_q.size() == 0) first_pop_cyc = cyc;
        got_q.push_back(m_bus.data);
        checkOutput("m_data", 32'(m_bus.data), 32'(exp_q.pop_front()));
        fifo_m--;
        pop_total++;
      end
      if (m_ena) begin
        hist.push_back(s_bus.valid ? s_bus.data : '0);
        if (hist.size() > NTAPS) void'(hist.pop_front());
      end
      if (acc_m) begin
        exp_q.push_back(refFilter());
        inflight_m++;
        acc_total++;
      end
      if (cap_m) begin
        inflight_m--;
        fifo_m++;
      end
      if (s_bus.valid && !m_ena && (stall_m != 16'hFFFF)) stall_m++;
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] value, output int acc_cyc);
    logic taken  = 1'b0;
    int   waited = 0;
    s_bus.valid = 1'b1;
    s_bus.data  = value;
    while (!taken && waited < 200) begin
      @(negedge clk);
      taken = s_bus.ready;
      @(posedge clk);
      #1;
      waited++;
    end
    acc_cyc = cyc;
    if (!taken) reportTimeout("accept");
  endtask

  task automatic waitOutputs(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      stepCycles(1);
      k++;
    end
    if (got_q.size() < n) reportTimeout("wait_outputs");
  endtask

  task automatic sendImpulse(output int e0);
    int dummy;
    applyStimulus(18'd1, e0);
    for (int i = 0; i < NTAPS - 1; i++) applyStimulus('0, dummy);
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
  endtask

  task automatic checkImpulse(input string tag);
    logic [DW-1:0] want;
    checkOutput({tag, "_count"}, 32'(got_q.size()), NTAPS);
    for (int i = 0; i < NTAPS && i < got_q.size(); i++) begin
      want = h[i][DW-1:0];
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(want));
    end
  endtask

  task automatic doReset();
    s_bus.valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_m_valid", 32'(m_bus.valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_bus.data), 32'd0);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_clk_ena", 32'(f_clk_ena), 32'd1);
    checkOutput("rst_s_ready", 32'(s_bus.ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          exp_i_valid;
    logic [DW-1:0] exp_i_in;
    logic          exp_ena;
    logic          exp_m_valid;
    logic          exp_idle;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int e0, a0, p0, k;
    vecs[0] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 18'h12345, 1'b0, 1'b1, 18'h12345, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 18'h3FFFF, 1'b1, 1'b1, 18'h3FFFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 18'h2AAAA, 1'b1, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 18'h20000, 1'b1, 1'b1, 18'h20000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 18'h3FFFF, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b1};

    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    m_bus.ready = 1'b0;
    #1 reset = 1'b0;

    // Reset values and combinational pass-through while held in reset.
    for (int i = 0; i < 6; i++) begin
      s_bus.valid = vecs[i].s_valid;
      s_bus.data  = vecs[i].s_data;
      m_bus.ready = vecs[i].m_ready;
      #1;
      checkOutput($sformatf("vec%0d_f_i_valid", i), 32'(f_i_valid), 32'(vecs[i].exp_i_valid));
      checkOutput($sformatf("vec%0d_f_i_in", i), 32'(f_i_in), 32'(vecs[i].exp_i_in));
      checkOutput($sformatf("vec%0d_clk_ena", i), 32'(f_clk_ena), 32'(vecs[i].exp_ena));
      checkOutput($sformatf("vec%0d_s_ready", i), 32'(s_bus.ready), 32'(vecs[i].exp_ena));
      checkOutput($sformatf("vec%0d_m_valid", i), 32'(m_bus.valid), 32'(vecs[i].exp_m_valid));
      checkOutput($sformatf("vec%0d_m_data", i), 32'(m_bus.data), 32'd0);
      checkOutput($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].exp_idle));
    end
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    m_bus.ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // No input: nothing may emerge.
    repeat (40) begin
      @(negedge clk);
      checkOutput("quiet_m_valid", 32'(m_bus.valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Impulse response, free-flowing.
    $display("[TB] impulse response");
    got_q.delete();
    sendImpulse(e0);
    waitOutputs(NTAPS, 100);
    checkOutput("impulse_latency", 32'(first_pop_cyc - e0), 32'd18);
    checkImpulse("impulse");
    stepCycles(2);
    checkOutput("impulse_idle", 32'(idle), 32'd1);

    // Backpressure: the FIFO fills and stalls the core, nothing lost.
    $display("[TB] backpressure");
    got_q.delete();
    m_bus.ready = 1'b0;
    sendImpulse(e0);
    while (cyc < e0 + 25) stepCycles(1);
    checkOutput("bp_fifo_count", 32'(dut.fifo_count), 32'd4);
    checkOutput("bp_clk_ena", 32'(f_clk_ena), 32'd0);
    checkOutput("bp_s_ready", 32'(s_bus.ready), 32'd0);
    checkOutput("bp_m_valid", 32'(m_bus.valid), 32'd1);
    while (cyc < e0 + 30) stepCycles(1);
    m_bus.ready = 1'b1;
    waitOutputs(NTAPS, 100);
    checkImpulse("backpressure");
    stepCycles(2);
    checkOutput("bp_idle", 32'(idle), 32'd1);

    // Random handshakes against the reference model.
    $display("[TB] random handshakes");
    a0 = acc_total;
    p0 = pop_total;
    k  = 0;
    while ((acc_total - a0) < 500 && k < 5000) begin
      s_bus.valid = 1'($urandom_range(0, 1));
      s_bus.data  = DW'($urandom);
      m_bus.ready = 1'($urandom_range(0, 1));
      stepCycles(1);
      k++;
    end
    if ((acc_total - a0) < 500) reportTimeout("random_accepts");
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    k = 0;
    while (!(inflight_m == 0 && fifo_m == 0) && k < 300) begin
      stepCycles(1);
      k++;
    end
    if (!(inflight_m == 0 && fifo_m == 0)) reportTimeout("random_drain");
    checkOutput("random_out_count", 32'(pop_total - p0), 32'd500);
    checkOutput("random_exp_left", 32'(exp_q.size()), 32'd0);
    stepCycles(20);

    // Mid-stream reset with 10 in flight and 3 buffered, then a clean impulse.
    $display("[TB] mid-stream reset");
    m_bus.ready = 1'b0;
    applyStimulus(18'd100, e0);
    for (int i = 1; i < 13; i++) applyStimulus(DW'(100 + i), a0);
    s_bus.valid = 1'b0;
    while (cyc < e0 + 20) stepCycles(1);
    checkOutput("mid_fifo_count", 32'(dut.fifo_count), 32'd3);
    checkOutput("mid_in_flight", 32'(dut.in_flight), 32'd10);
    doReset();
    m_bus.ready = 1'b1;
    got_q.delete();
    sendImpulse(e0);
    waitOutputs(NTAPS, 100);
    stepCycles(30);
    checkImpulse("post_reset");

`ifdef FIR_DRV_STALL_CNT_EN
    // Stall counter: 22 accepting cycles before the FIFO fills, the rest stall.
    $display("[TB] stall counter");
    doReset();
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1;
    repeat (100) begin
      s_bus.data = DW'($urandom_range(0, 255));
      stepCycles(1);
    end
    checkOutput("stall_cnt", 32'(stall_cnt), 32'd78);
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    k = 0;
    while (!(inflight_m == 0 && fifo_m == 0) && k < 300) begin
      stepCycles(1);
      k++;
    end
    if (!(inflight_m == 0 && fifo_m == 0)) reportTimeout("stall_drain");
`endif

    stepCycles(2);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, want $finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
